// File: rtl/sd_clk_ctrl.sv
// Sequencing controller for sd_clock_divider: glitch-free start/stop/divider change
// on SD_CLK low phases, plus the power-up burst of init clocks.
module sd_clk_ctrl #(
    parameter logic [7:0] DEFAULT_DIV = 8'd124,
    parameter int         INIT_CYCLES = 80
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CLK_EN,
    input  logic       CFG_REQ,
    input  logic [7:0] CFG_DIV,
    output logic       CFG_ACK,
    input  logic       INIT_REQ,
    output logic       INIT_DONE,
    input  logic       BUSY,
    input  logic       SD_CLK_IN,
    output logic [7:0] DIVIDER,
    output logic       DIV_RST,
    output logic       CLK_STABLE
);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_RUN,
        ST_CHG_WAIT,
        ST_CHG_RST,
        ST_STOP_WAIT,
        ST_INIT
    } state_t;

    localparam logic [7:0] INIT_LAST = 8'(INIT_CYCLES);

    state_t     state_reg, state_next;
    logic [7:0] pending_reg, pending_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       sd_q_reg;

    logic [7:0] divider_reg, divider_next;
    logic       div_rst_reg, div_rst_next;
    logic       cfg_ack_reg, cfg_ack_next;
    logic       init_done_reg, init_done_next;
    logic       clk_stable_reg, clk_stable_next;

    logic       sd_fall;
    logic       sd_rise;
    logic       cfg_take;

    assign sd_fall = sd_q_reg & ~SD_CLK_IN;
    assign sd_rise = ~sd_q_reg & SD_CLK_IN;
    // The requester holds CFG_REQ through the ack cycle; ignore it then so one request yields one ack.
    assign cfg_take = CFG_REQ & ~cfg_ack_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg      <= ST_OFF;
            pending_reg    <= 8'd0;
            cnt_reg        <= 8'd0;
            sd_q_reg       <= 1'b0;
            divider_reg    <= DEFAULT_DIV;
            div_rst_reg    <= 1'b1;
            cfg_ack_reg    <= 1'b0;
            init_done_reg  <= 1'b0;
            clk_stable_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pending_reg    <= pending_next;
            cnt_reg        <= cnt_next;
            sd_q_reg       <= SD_CLK_IN;
            divider_reg    <= divider_next;
            div_rst_reg    <= div_rst_next;
            cfg_ack_reg    <= cfg_ack_next;
            init_done_reg  <= init_done_next;
            clk_stable_reg <= clk_stable_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        cnt_next     = cnt_reg;
        case (state_reg)
            ST_OFF: begin
                if (!cfg_take && CLK_EN) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (INIT_REQ) begin
                    state_next = ST_INIT;
                    cnt_next   = 8'd0;
                end else if (!CLK_EN) begin
                    // A stop request outranks a divider change even while BUSY defers it.
                    if (!BUSY) begin
                        state_next = ST_STOP_WAIT;
                    end
                end else if (cfg_take && !BUSY) begin
                    state_next   = ST_CHG_WAIT;
                    pending_next = CFG_DIV;
                end
            end
            ST_CHG_WAIT: begin
                if (sd_fall) begin
                    state_next = ST_CHG_RST;
                end
            end
            ST_CHG_RST: begin
                state_next = ST_RUN;
            end
            ST_STOP_WAIT: begin
                if (CLK_EN) begin
                    state_next = ST_RUN;
                end else if (sd_fall) begin
                    state_next = ST_OFF;
                end
            end
            ST_INIT: begin
                if (sd_rise) begin
                    cnt_next = cnt_reg + 8'd1;
                    if (cnt_next == INIT_LAST) begin
                        state_next = ST_RUN;
                    end
                end
            end
            default: begin
                state_next = ST_OFF;
            end
        endcase
    end

    // Registered outputs follow the state being entered, so they line up with the new state.
    always_comb begin
        divider_next    = divider_reg;
        div_rst_next    = (state_next == ST_OFF) || (state_next == ST_CHG_RST);
        clk_stable_next = (state_next == ST_RUN) || (state_next == ST_INIT);
        cfg_ack_next    = (state_reg == ST_CHG_RST) || ((state_reg == ST_OFF) && cfg_take);
        init_done_next  = (state_reg == ST_INIT) && (state_next == ST_RUN);
        if ((state_reg == ST_OFF) && cfg_take) begin
            divider_next = CFG_DIV;
        end else if ((state_reg == ST_CHG_WAIT) && (state_next == ST_CHG_RST)) begin
            divider_next = pending_reg;
        end
    end

    assign DIVIDER    = divider_reg;
    assign DIV_RST    = div_rst_reg;
    assign CFG_ACK    = cfg_ack_reg;
    assign INIT_DONE  = init_done_reg;
    assign CLK_STABLE = clk_stable_reg;

endmodule

// File: tb/tb_sd_clk_ctrl.sv
// Directed bench for sd_clk_ctrl with a behavioural sd_clock_divider closing the loop.
module tb_sd_clk_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       CLK_EN = 1'b0;
    logic       CFG_REQ = 1'b0;
    logic [7:0] CFG_DIV = 8'd0;
    logic       CFG_ACK;
    logic       INIT_REQ = 1'b0;
    logic       INIT_DONE;
    logic       BUSY = 1'b0;
    logic       sd_clk;
    logic [7:0] DIVIDER;
    logic       DIV_RST;
    logic       CLK_STABLE;

    logic [7:0] div_cnt;
    int errors = 0;
    int checks = 0;
    int cfg_ack_cnt = 0;
    int init_done_cnt = 0;

    sd_clk_ctrl #(.DEFAULT_DIV(8'd2), .INIT_CYCLES(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .CLK_EN     (CLK_EN),
        .CFG_REQ    (CFG_REQ),
        .CFG_DIV    (CFG_DIV),
        .CFG_ACK    (CFG_ACK),
        .INIT_REQ   (INIT_REQ),
        .INIT_DONE  (INIT_DONE),
        .BUSY       (BUSY),
        .SD_CLK_IN  (sd_clk),
        .DIVIDER    (DIVIDER),
        .DIV_RST    (DIV_RST),
        .CLK_STABLE (CLK_STABLE)
    );

    always #5 CLK = ~CLK;

    // Divider: toggles SD_CLK every DIVIDER+1 CLK cycles, held low while DIV_RST is high.
    always @(posedge CLK or posedge DIV_RST) begin
        if (DIV_RST) begin
            div_cnt <= 8'd0;
            sd_clk  <= 1'b0;
        end else if (div_cnt == DIVIDER) begin
            div_cnt <= 8'd0;
            sd_clk  <= ~sd_clk;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    always @(posedge CLK) begin
        if (CFG_ACK === 1'b1) cfg_ack_cnt <= cfg_ack_cnt + 1;
        if (INIT_DONE === 1'b1) init_done_cnt <= init_done_cnt + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic measure_period(output int p);
        int n;
        n = 0;
        while (sd_clk !== 1'b0 && n < 64) begin tick(); n++; end
        while (sd_clk !== 1'b1 && n < 64) begin tick(); n++; end
        p = 0;
        while (sd_clk !== 1'b0 && p < 64) begin tick(); p++; end
        while (sd_clk !== 1'b1 && p < 64) begin tick(); p++; end
    endtask

    task automatic wait_div_rst(output bit ok, output logic p1, output logic p2);
        ok = 1'b0;
        p1 = sd_clk;
        p2 = 1'bx;
        for (int i = 0; i < 80; i++) begin
            p2 = p1;
            p1 = sd_clk;
            tick();
            if (DIV_RST === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rise(output bit ok);
        logic prev;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            prev = sd_clk;
            tick();
            if (sd_clk === 1'b1 && prev === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int   per;
        int   acks0;
        int   dones0;
        int   rises;
        int   done_at;
        int   expect_at;
        int   ack_at;
        bit   ok;
        logic p1;
        logic p2;
        logic prev;

        // Reset values
        tick();
        tick();
        check("rst_divider", DIVIDER, 8'd2);
        check("rst_div_rst", DIV_RST, 1'b1);
        check("rst_cfg_ack", CFG_ACK, 1'b0);
        check("rst_init_done", INIT_DONE, 1'b0);
        check("rst_clk_stable", CLK_STABLE, 1'b0);
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("off_div_rst_hold", DIV_RST, 1'b1);
        end
        check("off_sd_clk_low", sd_clk, 1'b0);

        // Start the clock
        CLK_EN = 1'b1;
        #1;
        check("start_div_rst_before_edge", DIV_RST, 1'b1);
        tick();
        check("start_div_rst_released", DIV_RST, 1'b0);
        check("start_clk_stable", CLK_STABLE, 1'b1);
        measure_period(per);
        check("period_div2", per, 6);

        // Divider change to 0 while idle
        acks0 = cfg_ack_cnt;
        CFG_DIV = 8'd0;
        CFG_REQ = 1'b1;
        tick();
        check("chg_wait_not_stable", CLK_STABLE, 1'b0);
        wait_div_rst(ok, p1, p2);
        check("chg0_div_rst_seen", ok, 1'b1);
        check("chg0_after_fall_low", p1, 1'b0);
        check("chg0_after_fall_high", p2, 1'b1);
        check("chg0_divider", DIVIDER, 8'd0);
        check("chg0_no_early_ack", CFG_ACK, 1'b0);
        tick();
        check("chg0_div_rst_one_cycle", DIV_RST, 1'b0);
        check("chg0_ack", CFG_ACK, 1'b1);
        CFG_REQ = 1'b0;
        tick();
        check("chg0_ack_single", CFG_ACK, 1'b0);
        check("chg0_ack_count", cfg_ack_cnt - acks0, 1);
        check("chg0_stable", CLK_STABLE, 1'b1);
        measure_period(per);
        check("period_div0", per, 2);

        // Divider change to 2 deferred by BUSY
        acks0 = cfg_ack_cnt;
        BUSY = 1'b1;
        CFG_DIV = 8'd2;
        CFG_REQ = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("busy_no_div_rst", DIV_RST, 1'b0);
            check("busy_no_ack", CFG_ACK, 1'b0);
            check("busy_divider_held", DIVIDER, 8'd0);
        end
        BUSY = 1'b0;
        wait_div_rst(ok, p1, p2);
        check("busy_div_rst_seen", ok, 1'b1);
        check("busy_after_fall_low", p1, 1'b0);
        check("busy_after_fall_high", p2, 1'b1);
        check("busy_divider", DIVIDER, 8'd2);
        tick();
        check("busy_ack", CFG_ACK, 1'b1);
        CFG_REQ = 1'b0;
        tick();
        check("busy_ack_count", cfg_ack_cnt - acks0, 1);
        measure_period(per);
        check("period_div2_again", per, 6);

        // Init burst with a divider request arriving mid-burst
        dones0 = init_done_cnt;
        rises = 0;
        done_at = -1;
        expect_at = -2;
        ack_at = -1;
        prev = sd_clk;
        INIT_REQ = 1'b1;
        tick();
        INIT_REQ = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if (INIT_DONE === 1'b1 && done_at < 0) done_at = i;
            if (CFG_ACK === 1'b1 && ack_at < 0) begin
                ack_at = i;
                CFG_REQ = 1'b0;
            end
            if (sd_clk === 1'b1 && prev === 1'b0) begin
                rises++;
                if (rises == 4) expect_at = i + 1;
            end
            prev = sd_clk;
            if (i == 1) check("init_stable", CLK_STABLE, 1'b1);
            if (i == 2) begin
                CFG_DIV = 8'd1;
                CFG_REQ = 1'b1;
            end
            tick();
        end
        check("init_done_timing", done_at, expect_at);
        check("init_done_count", init_done_cnt - dones0, 1);
        check("init_cfg_acked", ack_at >= 0, 1'b1);
        check("init_ack_after_done", ack_at > done_at, 1'b1);
        check("init_divider", DIVIDER, 8'd1);
        measure_period(per);
        check("period_div1", per, 4);

        // Stop while SD_CLK is high
        wait_rise(ok);
        check("stop_rise_seen", ok, 1'b1);
        CLK_EN = 1'b0;
        tick();
        check("stop_high_sd", sd_clk, 1'b1);
        check("stop_high_no_rst", DIV_RST, 1'b0);
        check("stop_not_stable", CLK_STABLE, 1'b0);
        tick();
        check("stop_fall_sd", sd_clk, 1'b0);
        check("stop_fall_no_rst", DIV_RST, 1'b0);
        tick();
        check("stop_div_rst", DIV_RST, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        check("stop_sd_held_low", sd_clk, 1'b0);
        check("stop_div_rst_held", DIV_RST, 1'b1);

        // Divider change in OFF
        acks0 = cfg_ack_cnt;
        CFG_DIV = 8'd9;
        CFG_REQ = 1'b1;
        tick();
        check("off_cfg_divider", DIVIDER, 8'd9);
        check("off_cfg_ack", CFG_ACK, 1'b1);
        CFG_REQ = 1'b0;
        tick();
        check("off_cfg_ack_single", CFG_ACK, 1'b0);
        check("off_cfg_ack_count", cfg_ack_cnt - acks0, 1);
        check("off_still_reset", DIV_RST, 1'b1);

        // INIT_REQ outside RUN is ignored
        dones0 = init_done_cnt;
        INIT_REQ = 1'b1;
        tick();
        INIT_REQ = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("off_init_ignored", init_done_cnt - dones0, 0);
        check("off_init_still_off", DIV_RST, 1'b1);

        // Reset during a pending change
        CLK_EN = 1'b1;
        tick();
        check("run_div9", DIV_RST, 1'b0);
        wait_rise(ok);
        check("rst_test_rise_seen", ok, 1'b1);
        acks0 = cfg_ack_cnt;
        CFG_DIV = 8'd5;
        CFG_REQ = 1'b1;
        tick();
        check("rst_test_chg_wait", CLK_STABLE, 1'b0);
        tick();
        tick();
        #2;
        RST = 1'b1;
        CFG_REQ = 1'b0;
        CLK_EN = 1'b0;
        #1;
        check("midrst_divider", DIVIDER, 8'd2);
        check("midrst_div_rst", DIV_RST, 1'b1);
        check("midrst_cfg_ack", CFG_ACK, 1'b0);
        check("midrst_stable", CLK_STABLE, 1'b0);
        check("midrst_sd_low", sd_clk, 1'b0);
        tick();
        tick();
        RST = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("midrst_no_ack", cfg_ack_cnt - acks0, 0);
        check("midrst_divider_after", DIVIDER, 8'd2);
        check("midrst_off", DIV_RST, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
